// File: rtl/bit_serial_subtractor_if.sv
// Bit-serial subtractor bus: serial operand inputs plus serial and parallel results.
interface bit_serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             start;
  logic             A;
  logic             B;
  logic             Borrow_in;
  logic             Diff;
  logic             Borrow_out;
  logic             out_valid;
  logic             word_done;
  logic [WIDTH-1:0] diff_word;
  logic             busy;

  // Operand source / result consumer side
  modport master (
    output in_valid, start, A, B, Borrow_in,
    input  Diff, Borrow_out, out_valid, word_done, diff_word, busy
  );

  // Subtractor side
  modport slave (
    input  in_valid, start, A, B, Borrow_in,
    output Diff, Borrow_out, out_valid, word_done, diff_word, busy
  );
endinterface

// File: rtl/bit_serial_subtractor.sv
// LSB-first bit-serial subtractor: D = A - B - Borrow_in over a WIDTH-bit word.
// One registered stage from accepted input bit to Diff/Borrow_out/out_valid;
// the finished word is presented on diff_word with a one-cycle word_done pulse.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bit_serial_subtractor_if.slave bus
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Difference bit of a full subtractor
  function automatic logic sub_diff(input logic a, input logic b, input logic bin);
    return a ^ b ^ bin;
  endfunction

  // Borrow out of a full subtractor
  function automatic logic sub_borrow(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             ov_q, ov_d;
  logic             wd_q, wd_d;
  logic [WIDTH-1:0] dw_q, dw_d;

  logic          accept;
  logic          last_bit;
  logic          b0;
  logic          d_bit;
  logic          bo_bit;
  logic [IW-1:0] wr_idx;

  // A bit is taken when valid and either a word is running or it opens a new one;
  // a start always reloads the borrow, which is how a start on the MSB wins.
  assign accept   = bus.in_valid & (bus.start | (state_q == ST_RUN));
  assign last_bit = (state_q == ST_RUN) & (idx_q == LAST_IDX) & ~bus.start;
  assign b0       = bus.start ? bus.Borrow_in : br_q;
  assign d_bit    = sub_diff(bus.A, bus.B, b0);
  assign bo_bit   = sub_borrow(bus.A, bus.B, b0);
  assign wr_idx   = bus.start ? {IW{1'b0}} : idx_q;

  // State register: FSM state and bit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= {IW{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic: start opens/restarts a word, the MSB closes it, no valid stalls
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && bus.start) begin
          state_d = ST_RUN;
          idx_d   = IW'(1);
        end else begin
          state_d = ST_IDLE;
          idx_d   = idx_q;
        end
      end
      ST_RUN: begin
        if (bus.in_valid && bus.start) begin
          state_d = ST_RUN;
          idx_d   = IW'(1);
        end else if (bus.in_valid && (idx_q == LAST_IDX)) begin
          state_d = ST_IDLE;
          idx_d   = {IW{1'b0}};
        end else if (bus.in_valid) begin
          state_d = ST_RUN;
          idx_d   = idx_q + IW'(1);
        end else begin
          state_d = ST_RUN;
          idx_d   = idx_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = {IW{1'b0}};
      end
    endcase
  end

  // Output logic: next values for borrow, shift register and all registered outputs.
  // Stale sr bits from an aborted word are simply overwritten by the new word.
  always_comb begin
    br_d   = br_q;
    sr_d   = sr_q;
    diff_d = diff_q;
    bo_d   = bo_q;
    ov_d   = 1'b0;
    wd_d   = 1'b0;
    dw_d   = dw_q;
    if (accept) begin
      br_d         = bo_bit;
      sr_d[wr_idx] = d_bit;
      diff_d       = d_bit;
      bo_d         = bo_bit;
      ov_d         = 1'b1;
      if (last_bit) begin
        wd_d = 1'b1;
        dw_d = {d_bit, sr_q[WIDTH-2:0]};
      end else begin
        wd_d = 1'b0;
        dw_d = dw_q;
      end
    end else begin
      ov_d = 1'b0;
      wd_d = 1'b0;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_q   <= 1'b0;
      sr_q   <= {WIDTH{1'b0}};
      diff_q <= 1'b0;
      bo_q   <= 1'b0;
      ov_q   <= 1'b0;
      wd_q   <= 1'b0;
      dw_q   <= {WIDTH{1'b0}};
    end else begin
      br_q   <= br_d;
      sr_q   <= sr_d;
      diff_q <= diff_d;
      bo_q   <= bo_d;
      ov_q   <= ov_d;
      wd_q   <= wd_d;
      dw_q   <= dw_d;
    end
  end

  assign bus.Diff       = diff_q;
  assign bus.Borrow_out = bo_q;
  assign bus.out_valid  = ov_q;
  assign bus.word_done  = wd_q;
  assign bus.diff_word  = dw_q;
  assign bus.busy       = (state_q == ST_RUN);

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed self-checking bench for bit_serial_subtractor (WIDTH = 8).
module tb_bit_serial_subtractor;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bit_serial_subtractor_if #(.WIDTH(W)) bus ();

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic a, input logic b, input logic bi);
    bus.in_valid  = v;
    bus.start     = st;
    bus.A         = a;
    bus.B         = b;
    bus.Borrow_in = bi;
  endtask

  // Drive bits lo..hi of a word back-to-back; start accompanies bit 0.
  task automatic send_range(input logic [7:0] a, input logic [7:0] b, input logic bi,
                            input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(1'b1, (i == 0), a[i], b[i], bi);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    total++;
    if ({bus.Diff, bus.Borrow_out, bus.out_valid, bus.word_done, bus.busy} !== 5'b00000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {bus.Diff, bus.Borrow_out, bus.out_valid, bus.word_done, bus.busy});
    end
    total++;
    if (bus.diff_word !== 8'h00) begin
      bad++;
      $display("FAIL reset_word got=%h want=00", bus.diff_word);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] a, b, exp_d, exp_b;
    a = 8'h5A; b = 8'h3C; exp_d = 8'h1E; exp_b = 8'h3C;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, (i == 0), a[i], b[i], 1'b0);
      tick();
      total++;
      if ({bus.Diff, bus.Borrow_out, bus.out_valid, bus.word_done, bus.busy} !==
          {exp_d[i], exp_b[i], 1'b1, (i == W - 1), (i != W - 1)}) begin
        bad++;
        $display("FAIL basic_bit%0d got=%b want=%b", i,
                 {bus.Diff, bus.Borrow_out, bus.out_valid, bus.word_done, bus.busy},
                 {exp_d[i], exp_b[i], 1'b1, (i == W - 1), (i != W - 1)});
      end
    end
    total++;
    if (bus.diff_word !== 8'h1E) begin
      bad++;
      $display("FAIL basic_word got=%h want=1e", bus.diff_word);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if ({bus.out_valid, bus.word_done, bus.diff_word} !== {1'b0, 1'b0, 8'h1E}) begin
      bad++;
      $display("FAIL basic_after got=%b/%b/%h want=0/0/1e",
               bus.out_valid, bus.word_done, bus.diff_word);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] a, b;
    a = 8'h00; b = 8'h01;
    for (int i = 0; i < W; i++) begin
      drive(1'b1, (i == 0), a[i], b[i], 1'b0);
      tick();
      total++;
      if ({bus.Borrow_out, bus.out_valid, bus.Diff} !== 3'b111) begin
        bad++;
        $display("FAIL underflow_bit%0d got=%b want=111", i,
                 {bus.Borrow_out, bus.out_valid, bus.Diff});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.word_done, bus.diff_word} !== {1'b1, 8'hFF}) begin
      bad++;
      $display("FAIL underflow_word got=%b/%h want=1/ff", bus.word_done, bus.diff_word);
    end
  endtask

  task automatic test_borrow_in();
    send_range(8'h10, 8'h0F, 1'b1, 0, W - 1);
    total++;
    if ({bus.word_done, bus.Borrow_out, bus.diff_word} !== {1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL borrow_in got=%b/%b/%h want=1/0/00",
               bus.word_done, bus.Borrow_out, bus.diff_word);
    end
  endtask

  task automatic test_stall();
    int cycles, done_at;
    logic [7:0] a, b;
    a = 8'h5A; b = 8'h3C;
    cycles = 0; done_at = -1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i == 0), a[i], b[i], 1'b0);
      tick();
      cycles++;
    end
    for (int s = 0; s < 3; s++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      cycles++;
      total++;
      if ({bus.out_valid, bus.word_done, bus.Diff, bus.Borrow_out, bus.busy} !== 5'b00111) begin
        bad++;
        $display("FAIL stall_cyc%0d got=%b want=00111", s,
                 {bus.out_valid, bus.word_done, bus.Diff, bus.Borrow_out, bus.busy});
      end
    end
    for (int i = 3; i < W; i++) begin
      drive(1'b1, 1'b0, a[i], b[i], 1'b0);
      tick();
      cycles++;
      if (bus.word_done === 1'b1) done_at = cycles;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (done_at !== 11) begin
      bad++;
      $display("FAIL stall_latency got=%0d want=11", done_at);
    end
    total++;
    if (bus.diff_word !== 8'h1E) begin
      bad++;
      $display("FAIL stall_word got=%h want=1e", bus.diff_word);
    end
  endtask

  task automatic test_abort();
    logic [7:0] a, b, c, d;
    int seen;
    a = 8'hFF; b = 8'h01; c = 8'h03; d = 8'h01;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0), a[i], b[i], 1'b0);
      tick();
      if (bus.word_done === 1'b1) seen++;
    end
    for (int i = 0; i < W; i++) begin
      drive(1'b1, (i == 0), c[i], d[i], 1'b0);
      tick();
      if (i < W - 1 && bus.word_done === 1'b1) seen++;
      if (i == 0) begin
        total++;
        if ({bus.busy, bus.out_valid, bus.Diff} !== 3'b110) begin
          bad++;
          $display("FAIL abort_restart got=%b want=110", {bus.busy, bus.out_valid, bus.Diff});
        end
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_no_done got=%0d want=0", seen);
    end
    total++;
    if ({bus.word_done, bus.Borrow_out, bus.diff_word} !== {1'b1, 1'b0, 8'h02}) begin
      bad++;
      $display("FAIL abort_word got=%b/%b/%h want=1/0/02",
               bus.word_done, bus.Borrow_out, bus.diff_word);
    end
  endtask

  task automatic test_start_msb();
    logic [7:0] a, b;
    a = 8'h5A; b = 8'h3C;
    send_range(a, b, 1'b0, 0, W - 2);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if ({bus.word_done, bus.busy, bus.out_valid, bus.Diff} !== 4'b0111) begin
      bad++;
      $display("FAIL start_msb got=%b want=0111",
               {bus.word_done, bus.busy, bus.out_valid, bus.Diff});
    end
    send_range(8'h01, 8'h00, 1'b0, 1, W - 1);
    total++;
    if ({bus.word_done, bus.diff_word} !== {1'b1, 8'h01}) begin
      bad++;
      $display("FAIL start_msb_word got=%b/%h want=1/01", bus.word_done, bus.diff_word);
    end
  endtask

  task automatic test_back_to_back();
    send_range(8'h00, 8'h01, 1'b0, 0, W - 1);
    total++;
    if ({bus.word_done, bus.diff_word} !== {1'b1, 8'hFF}) begin
      bad++;
      $display("FAIL b2b_first got=%b/%h want=1/ff", bus.word_done, bus.diff_word);
    end
    send_range(8'h5A, 8'h3C, 1'b0, 0, W - 1);
    total++;
    if ({bus.word_done, bus.diff_word, bus.Borrow_out} !== {1'b1, 8'h1E, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second got=%b/%h/%b want=1/1e/0",
               bus.word_done, bus.diff_word, bus.Borrow_out);
    end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      total++;
      if ({bus.out_valid, bus.busy, bus.word_done, bus.Diff} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_ignore%0d got=%b want=0000", i,
                 {bus.out_valid, bus.busy, bus.word_done, bus.Diff});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    logic [7:0] a, b;
    a = 8'h5A; b = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, (i == 0), a[i], b[i], 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, a[5], b[5], 1'b0);
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.Diff, bus.Borrow_out, bus.out_valid, bus.word_done, bus.busy, bus.diff_word} !==
        {5'b00000, 8'h00}) begin
      bad++;
      $display("FAIL midreset_outputs got=%b want=0000000000000",
               {bus.Diff, bus.Borrow_out, bus.out_valid, bus.word_done, bus.busy, bus.diff_word});
    end
    tick();
    rst_n = 1'b1;
    for (int i = 6; i < W; i++) begin
      drive(1'b1, 1'b0, a[i], b[i], 1'b0);
      tick();
      total++;
      if ({bus.out_valid, bus.busy} !== 2'b00) begin
        bad++;
        $display("FAIL midreset_inflight%0d got=%b want=00", i, {bus.out_valid, bus.busy});
      end
    end
    send_range(a, b, 1'b0, 0, W - 1);
    total++;
    if ({bus.word_done, bus.diff_word} !== {1'b1, 8'h1E}) begin
      bad++;
      $display("FAIL midreset_word got=%b/%h want=1/1e", bus.word_done, bus.diff_word);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_in();
    test_stall();
    test_abort();
    test_start_msb();
    test_back_to_back();
    test_idle_ignore();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
